// File: rtl/pop_sched_pkg.sv
// Shared constants, state encoding and helpers for the five-queue pop scheduler.
package pop_sched_pkg;

    localparam int unsigned NUM_Q = 5;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_Q-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (oh[i]) idx |= IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first eligible queue after rr_ptr, wrapping modulo NUM_Q.
module rr_pick
    import pop_sched_pkg::*;
(
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic [NUM_Q-1:0] elig,
    output logic             found,
    output logic [IDX_W-1:0] next_idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found    = 1'b0;
        next_idx = rr_ptr;
        cand     = '0;
        // k = NUM_Q revisits rr_ptr itself, so a lone eligible queue is still found.
        for (int unsigned k = 1; k <= NUM_Q; k++) begin
            cand = IDX_W'((32'(rr_ptr) + k) % NUM_Q);
            if (!found && elig[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

endmodule

// File: rtl/pop_scheduler.sv
// Round-robin pop scheduler for a five-queue bank with registered one-hot pops.
// Optional burst granting is enabled by defining POP_SCHED_BURST_EN.
module pop_scheduler
    import pop_sched_pkg::*;
#(
    parameter int unsigned TOT_W = 8
`ifdef POP_SCHED_BURST_EN
    , parameter int unsigned BURST_MAX = 4
`endif
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enable,
    input  logic             pause_in,
    input  logic             empty_0,
    input  logic             empty_1,
    input  logic             empty_2,
    input  logic             empty_3,
    input  logic             empty_4,
    output logic             pop_0,
    output logic             pop_1,
    output logic             pop_2,
    output logic             pop_3,
    output logic             pop_4,
    output logic             valid_out,
    output logic [IDX_W-1:0] grant_idx,
    output logic [TOT_W-1:0] pop_total,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [NUM_Q-1:0] pop_q, pop_d;
    logic [IDX_W-1:0] grant_q;
    logic [TOT_W-1:0] total_q;

    logic [NUM_Q-1:0] elig;
    logic             found;
    logic [IDX_W-1:0] pick_idx;
    logic             issue;
    logic [IDX_W-1:0] issue_idx;

`ifdef POP_SCHED_BURST_EN
    localparam int unsigned       BCNT_W    = $clog2(BURST_MAX + 1);
    localparam logic [BCNT_W-1:0] BURST_LIM = BCNT_W'(BURST_MAX);
    logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

    assign elig = ~{empty_4, empty_3, empty_2, empty_1, empty_0};

    rr_pick u_rr_pick (
        .rr_ptr   (rr_ptr_q),
        .elig     (elig),
        .found    (found),
        .next_idx (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        issue_idx = pick_idx;
        pop_d     = '0;
`ifdef POP_SCHED_BURST_EN
        burst_cnt_d = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (pause_in)   state_d = ST_HOLD;
                    else if (found) state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (pause_in) begin
                    state_d = ST_HOLD;
                end else if (!found) begin
                    state_d = ST_IDLE;
                end else begin
`ifdef POP_SCHED_BURST_EN
                    // A burst that hit its limit costs one dead cycle before re-arbitrating.
                    if (burst_cnt_q >= BURST_LIM) begin
                        burst_cnt_d = '0;
                    end else if (burst_cnt_q != '0 && elig[rr_ptr_q]) begin
                        issue       = 1'b1;
                        issue_idx   = rr_ptr_q;
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end else begin
                        issue       = 1'b1;
                        burst_cnt_d = BCNT_W'(1);
                    end
`else
                    issue = 1'b1;
`endif
                end
            end
            ST_HOLD: begin
                if (!enable)        state_d = ST_IDLE;
                else if (!pause_in) state_d = ST_ARB;
            end
            default: state_d = ST_IDLE;
        endcase
        if (issue) pop_d = NUM_Q'(1) << issue_idx;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= IDX_W'(NUM_Q - 1);
            pop_q    <= '0;
            grant_q  <= '0;
            total_q  <= '0;
        end else begin
            state_q <= state_d;
            pop_q   <= pop_d;
            if (issue) begin
                rr_ptr_q <= issue_idx;
                grant_q  <= onehot_to_idx(pop_d);
                total_q  <= total_q + 1'b1;
            end
        end
    end

`ifdef POP_SCHED_BURST_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) burst_cnt_q <= '0;
        else          burst_cnt_q <= burst_cnt_d;
    end
`endif

    assign pop_0     = pop_q[0];
    assign pop_1     = pop_q[1];
    assign pop_2     = pop_q[2];
    assign pop_3     = pop_q[3];
    assign pop_4     = pop_q[4];
    assign valid_out = |pop_q;
    assign grant_idx = grant_q;
    assign pop_total = total_q;
    assign busy      = (state_q == ST_ARB) || (state_q == ST_HOLD);

endmodule

// File: doc/pop_scheduler.md
Name: pop_scheduler

Overview:
- Round-robin pop scheduler for the five-queue bank whose pop events feed the per-queue pop counters.
- Watches the queue empty flags and downstream backpressure.
- Issues at most one one-hot pop per cycle, with fair rotation.
- Reports the granted queue index and a running pop total, so the counter block can be indexed by the queue just served.

Parameters:
- NUM_Q, 5, number of queues; fixed at 5 because the ports are scalar.
- IDX_W, 3, width of grant_idx.
- BURST_MAX, 4, maximum consecutive grants to one queue. Used only when the optional feature is enabled.
- TOT_W, 8, width of pop_total.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scheduling allowed.
- pause_in  in  1  downstream almost-full; 1 = issue no new pop.
- empty_0 .. empty_4  in  1 each  1 = queue i empty. The FIFO updates this on the same edge that consumes a pop.
- pop_0 .. pop_4  out  1 each  registered one-hot pop strobes; at most one high.
- valid_out  out  1  1 when any pop_i is high this cycle.
- grant_idx  out  IDX_W  index of the queue popped this cycle; holds its last value when valid_out=0.
- pop_total  out  TOT_W  count of pops issued since reset.
- busy  out  1  1 when the FSM is in ARB or HOLD.

Behaviour:
- Reset (reset_L=0, takes effect immediately, no clock needed):
  - pop_0..4=0, valid_out=0, grant_idx=0, pop_total=0, busy=0.
  - State IDLE; rr_ptr=4, so the first grant goes to queue 0.
  - Burst counter=0.
- Eligibility: queue i is eligible when empty_i=0.
- Pick rule: search i = rr_ptr+1, rr_ptr+2, … modulo 5 (4 wraps to 0), and take the first eligible queue. rr_ptr only ever holds 0..4.
- Latency: the decision uses inputs sampled at edge N, and the pops are registered, so pop_i is high during cycle N+1 (1-cycle latency). On a grant, rr_ptr, grant_idx and pop_total update on the same edge.
- FSM states:
  - IDLE:
    - Outputs low.
    - Go to ARB when enable=1, pause_in=0 and some queue is eligible.
    - Go to HOLD when enable=1 and pause_in=1.
  - ARB:
    - Each cycle, if an eligible queue exists, register its pop.
    - Go to HOLD if pause_in=1.
    - Go to IDLE if enable=0 or no queue is eligible. No pop is issued on the cycle of that decision.
  - HOLD:
    - No pops; rr_ptr is frozen.
    - Go to ARB when pause_in=0 and enable=1.
    - Go to IDLE when enable=0.
- Simultaneous events:
  - pause_in wins over a pending grant.
  - enable=0 wins over everything except reset.
  - When an empty flag and a grant change on the same edge, the newly sampled flag is used.
- pop_total wraps from 2^TOT_W−1 to 0 with no saturation and no flag.
- Never pop an empty queue: a pop is issued only if empty_i=0 was sampled on the deciding edge.
- Reset mid-burst or mid-pop clears everything. The interrupted pop is dropped, not replayed.

Optional Feature:
- Macro POP_SCHED_BURST_EN.
- Defined:
  - The granted queue stays granted on consecutive cycles while it remains eligible and burst_cnt < BURST_MAX.
  - burst_cnt resets to 1 on each new grant.
  - A pause or idle ends the burst, and rr_ptr then points at the burst queue.
- Undefined: strict one-pop-per-grant rotation; no burst counter is synthesised.

Decomposition:
- Shared package pop_sched_pkg holds:
  - NUM_Q and IDX_W.
  - State encodings ST_IDLE=2'd0, ST_ARB=2'd1, ST_HOLD=2'd2.
  - The one-hot-to-index helper function.
- Sub-module rr_pick: purely combinational. Takes rr_ptr and the 5-bit eligibility vector; returns found plus the next index.
- The top level holds the FSM, the output registers and the counters.

Test Plan:
- Reset with all queues non-empty and enable=1 → first pop_0 at the 2nd edge after reset_L rises, then pop_1, pop_2, pop_3, pop_4, pop_0; grant_idx follows 0,1,2,3,4,0.
- empty_1=1 and empty_3=1, others 0 → pop order 0,2,4,0,2; pops 1 and 3 never assert.
- pause_in=1 for 3 cycles after the grant to queue 2 → no pops for those cycles; the next pop after release is queue 3; busy stays 1.
- 260 pops issued → pop_total reads 4 (wrap past 255); one-hot check holds on every cycle.
- reset_L pulled low asynchronously mid-cycle while pop_4=1 → all outputs 0 before the next edge; after release the next grant is queue 0.
- With POP_SCHED_BURST_EN and only queue 2 non-empty for 6 pops → pop_2 high 4 cycles, 1 dead arbitration cycle, then pop_2 again. Without the macro → pop_2 every cycle.
